// File: rtl/vga_timing_gen_pkg.sv
// Shared types and mode constants for the VGA raster timing generator.
// Both standard modes are described as whole-mode structs so callers pick one set.
package vga_timing_gen_pkg;

  typedef struct packed {
    int h_vis;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_vis;
    int v_fp;
    int v_sync;
    int v_bp;
    bit h_pol;
    bit v_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60 = '{
    h_vis: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_vis: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    h_pol: 1'b0, v_pol: 1'b0
  };

  function automatic vga_mode_t mode_800x600_72();
    return '{
      h_vis: 800, h_fp: 56, h_sync: 120, h_bp: 64,
      v_vis: 600, v_fp: 37, v_sync: 6,   v_bp: 23,
      h_pol: 1'b1, v_pol: 1'b1
    };
  endfunction

  // Total period of one axis: visible + front porch + sync + back porch.
  function automatic int span4(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  // Per-coordinate decode bits carried down the latency-matching delay line.
  typedef struct packed {
    logic frame;
    logic line;
    logic vs;
    logic hs;
    logic vis;
  } tap_t;

  localparam int TAP_W = $bits(tap_t);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the timing generator: fetch coordinates out, pixel in, pins out.
// en qualifies every clock edge; there is no backpressure, a cleared en simply freezes the raster.
interface vga_timing_gen_if #(
  parameter int PIX_W = 24,
  parameter int CNT_W = 11
);

  logic             en;
  logic [PIX_W-1:0] pixelIn;
  logic [PIX_W-1:0] pixelOut;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [CNT_W-1:0] posX;
  logic [CNT_W-1:0] posY;
  logic             frame_start;
  logic             line_start;

  modport master (
    input  en,
    input  pixelIn,
    output pixelOut,
    output hsync,
    output vsync,
    output de,
    output posX,
    output posY,
    output frame_start,
    output line_start
  );

  modport slave (
    output en,
    output pixelIn,
    input  pixelOut,
    input  hsync,
    input  vsync,
    input  de,
    input  posX,
    input  posY,
    input  frame_start,
    input  line_start
  );

endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register that delays decode bits to meet the frame-buffer read latency.
// DEPTH = 0 is a plain wire so a zero-latency pixel source needs no special casing upstream.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: issues fetch coordinates PIX_LAT cycles ahead and
// re-aligns sync, data enable, strobes and pixel data at a registered output stage.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   PIX_W   = 24,
  parameter int   CNT_W   = 11,
  parameter int   H_VIS   = MODE_640X480_60.h_vis,
  parameter int   H_FP    = MODE_640X480_60.h_fp,
  parameter int   H_SYNC  = MODE_640X480_60.h_sync,
  parameter int   H_BP    = MODE_640X480_60.h_bp,
  parameter int   V_VIS   = MODE_640X480_60.v_vis,
  parameter int   V_FP    = MODE_640X480_60.v_fp,
  parameter int   V_SYNC  = MODE_640X480_60.v_sync,
  parameter int   V_BP    = MODE_640X480_60.v_bp,
  parameter logic H_POL   = MODE_640X480_60.h_pol,
  parameter logic V_POL   = MODE_640X480_60.v_pol,
  parameter int   PIX_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOT = span4(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = span4(V_VIS, V_FP, V_SYNC, V_BP);

  if (H_TOT > 2**CNT_W) begin : g_bad_h_tot
    $error("vga_timing_gen: H_TOT %0d does not fit in CNT_W=%0d", H_TOT, CNT_W);
  end
  if (V_TOT > 2**CNT_W) begin : g_bad_v_tot
    $error("vga_timing_gen: V_TOT %0d does not fit in CNT_W=%0d", V_TOT, CNT_W);
  end
  if (PIX_LAT < 0 || PIX_LAT > 4) begin : g_bad_lat
    $error("vga_timing_gen: PIX_LAT %0d outside 0..4", PIX_LAT);
  end

  // Decode bounds are one bit wider so a sync or visible region ending exactly at 2**CNT_W still compares correctly.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W:0]   H_VIS_W  = (CNT_W+1)'(H_VIS);
  localparam logic [CNT_W:0]   V_VIS_W  = (CNT_W+1)'(V_VIS);
  localparam logic [CNT_W:0]   H_SS_W   = (CNT_W+1)'(H_VIS + H_FP);
  localparam logic [CNT_W:0]   H_SE_W   = (CNT_W+1)'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W:0]   V_SS_W   = (CNT_W+1)'(V_VIS + V_FP);
  localparam logic [CNT_W:0]   V_SE_W   = (CNT_W+1)'(V_VIS + V_FP + V_SYNC);

  logic             run;
  logic             adv;
  logic [CNT_W-1:0] pos_x;
  logic [CNT_W-1:0] pos_y;
  logic [CNT_W:0]   px_w;
  logic [CNT_W:0]   py_w;
  tap_t             raw;
  tap_t             dly;
  logic [TAP_W-1:0] dly_bits;

  logic [PIX_W-1:0] pixel_q;
  logic             de_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             frame_q;
  logic             line_q;

  // The first edge after reset release only arms the raster, so (0,0) is held for one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  assign adv = bus.en & run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (adv) begin
      if (pos_x == H_LAST) begin
        pos_x <= '0;
        pos_y <= (pos_y == V_LAST) ? '0 : pos_y + CNT_W'(1);
      end else begin
        pos_x <= pos_x + CNT_W'(1);
      end
    end
  end

  assign px_w = {1'b0, pos_x};
  assign py_w = {1'b0, pos_y};

  always_comb begin
    raw       = '0;
    raw.vis   = (px_w < H_VIS_W) && (py_w < V_VIS_W);
    raw.hs    = (px_w >= H_SS_W) && (px_w < H_SE_W);
    raw.vs    = (py_w >= V_SS_W) && (py_w < V_SE_W);
    raw.line  = (pos_x == '0);
    raw.frame = (pos_x == '0) && (pos_y == '0);
  end

  vga_delay_line #(
    .WIDTH (TAP_W),
    .DEPTH (PIX_LAT)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .din  (raw),
    .dout (dly_bits)
  );

  assign dly = tap_t'(dly_bits);

  // Strobes fall on every non-advancing edge so a frozen raster never repeats them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_q <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
    end else if (adv) begin
      pixel_q <= dly.vis ? bus.pixelIn : '0;
      de_q    <= dly.vis;
      hsync_q <= dly.hs ? H_POL : ~H_POL;
      vsync_q <= dly.vs ? V_POL : ~V_POL;
      frame_q <= dly.frame & dly.vis;
      line_q  <= dly.line & dly.vis;
    end else begin
      frame_q <= 1'b0;
      line_q  <= 1'b0;
    end
  end

  assign bus.posX        = pos_x;
  assign bus.posY        = pos_y;
  assign bus.pixelOut    = pixel_q;
  assign bus.de          = de_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.frame_start = frame_q;
  assign bus.line_start  = line_q;

endmodule
